midi_voice_allocator: RTL and testbench
=======================================

// Module: midi_voice_allocator
// PURPOSE
//  Parametrised MIDI-to-voice allocator and stepper-enable timeout for Stepper Synth V3.
//  Sits between the MIDI byte assembler and the per-voice pitch/velocity/StepperFM chain.
//  Maps Note On/Off and All-Notes-Off into NUM_VOICES voice slots.
//  Two mapping modes:
//   - fixed channel->voice mapping;
//   - polyphonic pool with retrigger and oldest-voice stealing.
// PARAMETERS
//  NUM_VOICES   8              number of stepper voices (1..16)
//  AGE_W        8              width of per-voice saturating age counter
//  TIMEOUT_CYC  1500000000     idle cycles before steppers disabled (30 s @ 50 MHz)
//  TMO_W        32             width of timeout counter; must hold TIMEOUT_CYC
// PORTS
//  Clk          in   1              system clock
//  Rst_p        in   1              synchronous reset, active-high
//  Msg_valid    in   1              Msg_data holds a complete 3-byte MIDI message
//  Msg_ready    out  1              allocator can accept a message (IDLE only)
//  Msg_data     in   24             {status, data1, data2}
//  Mode         in   1              0 = channel n -> voice n; 1 = polyphonic pool
//  Chan_mask    in   16             poly mode: bit n set = channel n accepted
//  Voice_note   out  7*NUM_VOICES   note per voice; voice i at [7i+6:7i]
//  Voice_vel    out  7*NUM_VOICES   velocity per voice; 0 when gate low
//  Voice_gate   out  NUM_VOICES     voice sounding
//  Steal        out  1              one-cycle pulse when an active voice is stolen
//  Enable       out  1              stepper driver enable, active-low (0 = drivers on)
// BEHAVIOUR
//  Reset:
//   - outputs: all Voice_* = 0, Steal = 0, Enable = 1, Msg_ready = 1.
//   - state: FSM = IDLE; ages and timeout counter = 0.
//   - Reset mid-message discards the message.
//  Handshake:
//   - Transfer occurs on an edge with Msg_valid & Msg_ready.
//   - Source holds Msg_data stable until that edge.
//   - Msg_ready is low in LOOKUP and COMMIT.
//  FSM IDLE -> LOOKUP -> COMMIT -> IDLE:
//   - Accept edge E0: message registered.
//   - E1: match/free/oldest search registered.
//   - E2: voice registers updated; outputs change at E2.
//   - Throughput: 1 message per 3 cycles.
//  Decode:
//   - Note On: 0x9n with data2 != 0.
//   - Note Off: 0x8n, or 0x9n with data2 == 0.
//   - All Notes Off: 0xBn with data1 == 123.
//   - Anything else is accepted and dropped: no state change except timeout reload.
//  Mode 0:
//   - Voice = channel n.
//   - n >= NUM_VOICES is dropped.
//   - Note On overwrites note and velocity, and sets gate.
//   - Note Off clears the gate only if the stored note == data1. A stale Off is ignored.
//  Mode 1, Note On (channel masked off -> dropped); first rule that applies wins:
//   - An active voice with same channel+note is retriggered: velocity updated, age = 0.
//   - Else the lowest-index free voice is taken.
//   - Else the oldest voice is stolen: max age, ties -> lowest index. Steal pulses on E2.
//  Mode 1, ages:
//   - On each committed Note On, every other active voice's age += 1, saturating at 2^AGE_W-1.
//   - The allocated voice's age = 0.
//  Mode 1, Note Off:
//   - Clears every active voice matching channel+note.
//  All Notes Off:
//   - Clears every voice of that channel (both modes).
//  Gate cleared:
//   - Voice_vel -> 0; Voice_note retained.
//  Mode change:
//   - Mode is sampled at E0. Voices are not cleared on a mode change.
//  Enable timeout:
//   - Counter reloads to TIMEOUT_CYC on every accepted message.
//   - Otherwise it decrements only while Voice_gate == 0, stopping at 0.
//   - Enable = 0 while counter != 0; Enable = 1 at 0. Registered, 1-cycle lag.
// STRUCTURE
//  midi_defs.vh (shared include):
//   - status nibbles NOTE_OFF=4'h8, NOTE_ON=4'h9, CTRL=4'hB;
//   - CC_ALL_NOTES_OFF=7'd123;
//   - FSM state encodings.
//  Sub-module voice_select:
//   - combinational match / lowest-free / oldest encoders over NUM_VOICES;
//   - outputs index + found flags.
// TESTING
//  1. Mode 0: 90 3C 64 then 80 3C 00
//     -> voice0 note=0x3C vel=0x64 gate=1 at E2; then gate=0, vel=0.
//  2. Mode 0: 91 40 50, then 81 41 00 (stale Off)
//     -> voice1 stays gated with note 0x40.
//  3. Mode 1, NUM_VOICES=4: Notes On 60,62,64,65 on ch0, then 67
//     -> voices 0-3 filled; 67 steals voice0; Steal pulses once.
//  4. Mode 1: repeat 90 3C 7F on an active 60
//     -> same voice retriggered, vel=0x7F, no new voice used, Steal=0.
//  5. B0 7B 00 with ch0 and ch1 voices active
//     -> only ch0 gates cleared; ch1 unchanged.
//  6. TIMEOUT_CYC=20: one message, then idle with no gates
//     -> Enable=0 for 20 cycles, then 1; Rst_p asserted mid-LOOKUP -> all voices 0, Msg_ready=1.

Source files
------------

// File: rtl/midi_voice_allocator_pkg.sv
// Shared definitions for the MIDI voice allocator: MIDI status nibbles,
// FSM states, the registered command record and a status decoder.
package midi_voice_allocator_pkg;

  localparam int unsigned MSG_W  = 24;
  localparam int unsigned NOTE_W = 7;
  localparam int unsigned CHAN_W = 4;

  localparam logic [3:0]        ST_NOTE_OFF      = 4'h8;
  localparam logic [3:0]        ST_NOTE_ON       = 4'h9;
  localparam logic [3:0]        ST_CTRL          = 4'hB;
  localparam logic [NOTE_W-1:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_ON   = 2'd1,
    CMD_OFF  = 2'd2,
    CMD_ANO  = 2'd3
  } cmd_kind_e;

  // Raw 3-byte MIDI message as delivered by the byte assembler.
  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
  } midi_msg_t;

  // Decoded message held from accept until commit.
  typedef struct packed {
    cmd_kind_e          kind;
    logic               poly;
    logic [CHAN_W-1:0]  chan;
    logic [NOTE_W-1:0]  note;
    logic [NOTE_W-1:0]  vel;
  } cmd_t;

  // Classify a message; Note On with zero velocity is treated as Note Off.
  function automatic cmd_kind_e decode_kind(input midi_msg_t m);
    cmd_kind_e k;
    k = CMD_NONE;
    case (m.status[7:4])
      ST_NOTE_ON:  k = (m.data2 != 8'd0) ? CMD_ON : CMD_OFF;
      ST_NOTE_OFF: k = CMD_OFF;
      ST_CTRL:     if (m.data1 == {1'b0, CC_ALL_NOTES_OFF}) k = CMD_ANO;
      default:     k = CMD_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/midi_voice_allocator_if.sv
// Message handshake between the MIDI byte assembler (master) and the
// voice allocator (slave).
//   Msg_valid : Msg_data holds a complete message
//   Msg_ready : allocator can take a message
//   Msg_data  : {status, data1, data2}
interface midi_voice_allocator_if;
  import midi_voice_allocator_pkg::*;

  logic      Msg_valid;
  logic      Msg_ready;
  midi_msg_t Msg_data;

  modport master (output Msg_valid, output Msg_data, input Msg_ready);
  modport slave  (input Msg_valid, input Msg_data, output Msg_ready);
endinterface

// File: rtl/midi_voice_allocator_voice_select.sv
// Combinational voice search over all slots.
//   gate_i/chan_i/note_i/age_i : current per-voice state
//   key_chan_i/key_note_i      : channel+note being looked up
//   match_*_c  : lowest active voice holding key channel+note
//   free_*_c   : lowest voice with gate low
//   oldest_idx_c : voice with maximum age, ties to lowest index
module midi_voice_allocator_voice_select
  import midi_voice_allocator_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned AGE_W      = 8,
  parameter int unsigned IDX_W      = 3
) (
  input  logic [NUM_VOICES-1:0]              gate_i,
  input  logic [NUM_VOICES-1:0][CHAN_W-1:0]  chan_i,
  input  logic [NUM_VOICES-1:0][NOTE_W-1:0]  note_i,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0]   age_i,
  input  logic [CHAN_W-1:0]                  key_chan_i,
  input  logic [NOTE_W-1:0]                  key_note_i,
  output logic                               match_found_c,
  output logic [IDX_W-1:0]                   match_idx_c,
  output logic                               free_found_c,
  output logic [IDX_W-1:0]                   free_idx_c,
  output logic [IDX_W-1:0]                   oldest_idx_c
);

  logic [AGE_W-1:0] best_age;

  // Ascending scan: first hit wins for match/free; strict '>' keeps lowest index on age ties.
  always_comb begin
    match_found_c = 1'b0;
    match_idx_c   = '0;
    free_found_c  = 1'b0;
    free_idx_c    = '0;
    oldest_idx_c  = '0;
    best_age      = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      if (!match_found_c && gate_i[i] && chan_i[i] == key_chan_i && note_i[i] == key_note_i) begin
        match_found_c = 1'b1;
        match_idx_c   = IDX_W'(i);
      end
      if (!free_found_c && !gate_i[i]) begin
        free_found_c = 1'b1;
        free_idx_c   = IDX_W'(i);
      end
      if (age_i[i] > best_age) begin
        best_age     = age_i[i];
        oldest_idx_c = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// MIDI-to-voice allocator with stepper-enable timeout.
//   Clk, Rst_p  : clock, synchronous active-high reset
//   msg         : message handshake (slave side)
//   Mode        : 0 = channel n -> voice n, 1 = polyphonic pool
//   Chan_mask   : channels accepted for Note On in poly mode
//   Voice_note  : 7-bit note per voice, voice i at [7i+6:7i]
//   Voice_vel   : 7-bit velocity per voice, 0 when gate low
//   Voice_gate  : per-voice sounding flag
//   Steal       : one-cycle pulse when an active voice is reassigned
//   Enable      : stepper driver enable, active-low
module midi_voice_allocator
  import midi_voice_allocator_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = 8,
  parameter int unsigned AGE_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 1500000000,
  parameter int unsigned TMO_W       = 32
) (
  input  logic                         Clk,
  input  logic                         Rst_p,
  midi_voice_allocator_if.slave        msg,
  input  logic                         Mode,
  input  logic [15:0]                  Chan_mask,
  output logic [NOTE_W*NUM_VOICES-1:0] Voice_note,
  output logic [NOTE_W*NUM_VOICES-1:0] Voice_vel,
  output logic [NUM_VOICES-1:0]        Voice_gate,
  output logic                         Steal,
  output logic                         Enable
);

  localparam int unsigned      IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC);

  state_e                            state_q, state_d;
  logic                              ready_q, ready_d;
  cmd_t                              cmd_q, cmd_d, cmd_in;
  logic [IDX_W-1:0]                  tgt_idx_q, tgt_idx_d;
  logic                              tgt_steal_q, tgt_steal_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] note_q, note_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] vel_q, vel_d;
  logic [NUM_VOICES-1:0]             gate_q, gate_d;
  logic [NUM_VOICES-1:0][CHAN_W-1:0] chan_q, chan_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0]  age_q, age_d;
  logic                              steal_q, steal_d;
  logic [TMO_W-1:0]                  tmo_q, tmo_d;
  logic                              enable_q, enable_d;

  logic             accept;
  logic             match_found, free_found;
  logic [IDX_W-1:0] match_idx, free_idx, oldest_idx;

  assign accept = ready_q & msg.Msg_valid;

  // Decode at accept; out-of-range or masked-off notes collapse to a no-op.
  always_comb begin
    cmd_in      = '0;
    cmd_in.kind = decode_kind(msg.Msg_data);
    cmd_in.poly = Mode;
    cmd_in.chan = msg.Msg_data.status[3:0];
    cmd_in.note = msg.Msg_data.data1[NOTE_W-1:0];
    cmd_in.vel  = msg.Msg_data.data2[NOTE_W-1:0];
    if (!Mode && (cmd_in.kind == CMD_ON || cmd_in.kind == CMD_OFF) &&
        32'(cmd_in.chan) >= NUM_VOICES)
      cmd_in.kind = CMD_NONE;
    if (Mode && cmd_in.kind == CMD_ON && !Chan_mask[cmd_in.chan])
      cmd_in.kind = CMD_NONE;
  end

  midi_voice_allocator_voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .IDX_W      (IDX_W)
  ) u_voice_select (
    .gate_i        (gate_q),
    .chan_i        (chan_q),
    .note_i        (note_q),
    .age_i         (age_q),
    .key_chan_i    (cmd_q.chan),
    .key_note_i    (cmd_q.note),
    .match_found_c (match_found),
    .match_idx_c   (match_idx),
    .free_found_c  (free_found),
    .free_idx_c    (free_idx),
    .oldest_idx_c  (oldest_idx)
  );

  // Next-state, voice update and timeout logic.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    cmd_d       = cmd_q;
    tgt_idx_d   = tgt_idx_q;
    tgt_steal_d = tgt_steal_q;
    note_d      = note_q;
    vel_d       = vel_q;
    gate_d      = gate_q;
    chan_d      = chan_q;
    age_d       = age_q;
    steal_d     = 1'b0;
    enable_d    = (tmo_q == '0);
    tmo_d       = tmo_q;

    // Reload on any accepted message; otherwise count down only while silent.
    if (accept)
      tmo_d = TMO_LOAD;
    else if (gate_q == '0 && tmo_q != '0)
      tmo_d = tmo_q - TMO_W'(1);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d   = cmd_in;
          state_d = S_LOOKUP;
          ready_d = 1'b0;
        end
      end

      // Allocation priority: retrigger, then lowest free, then steal oldest.
      S_LOOKUP: begin
        state_d     = S_COMMIT;
        tgt_steal_d = 1'b0;
        if (!cmd_q.poly)
          tgt_idx_d = IDX_W'(cmd_q.chan);
        else if (match_found)
          tgt_idx_d = match_idx;
        else if (free_found)
          tgt_idx_d = free_idx;
        else begin
          tgt_idx_d   = oldest_idx;
          tgt_steal_d = 1'b1;
        end
      end

      S_COMMIT: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
          case (cmd_q.kind)
            CMD_ON: begin
              if (IDX_W'(i) == tgt_idx_q) begin
                note_d[i] = cmd_q.note;
                vel_d[i]  = cmd_q.vel;
                gate_d[i] = 1'b1;
                chan_d[i] = cmd_q.chan;
                if (cmd_q.poly) age_d[i] = '0;
              end else if (cmd_q.poly && gate_q[i] && age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + AGE_W'(1);
              end
            end
            // Mode 0 matches the slot by index; poly matches the stored channel.
            CMD_OFF: begin
              if (gate_q[i] && note_q[i] == cmd_q.note &&
                  (cmd_q.poly ? (chan_q[i] == cmd_q.chan) : (CHAN_W'(i) == cmd_q.chan))) begin
                gate_d[i] = 1'b0;
                vel_d[i]  = '0;
              end
            end
            CMD_ANO: begin
              if (chan_q[i] == cmd_q.chan) begin
                gate_d[i] = 1'b0;
                vel_d[i]  = '0;
              end
            end
            default: ;
          endcase
        end
        if (cmd_q.kind == CMD_ON) steal_d = tgt_steal_q;
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (Rst_p) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      cmd_q       <= '0;
      tgt_idx_q   <= '0;
      tgt_steal_q <= 1'b0;
      note_q      <= '0;
      vel_q       <= '0;
      gate_q      <= '0;
      chan_q      <= '0;
      age_q       <= '0;
      steal_q     <= 1'b0;
      tmo_q       <= '0;
      enable_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      cmd_q       <= cmd_d;
      tgt_idx_q   <= tgt_idx_d;
      tgt_steal_q <= tgt_steal_d;
      note_q      <= note_d;
      vel_q       <= vel_d;
      gate_q      <= gate_d;
      chan_q      <= chan_d;
      age_q       <= age_d;
      steal_q     <= steal_d;
      tmo_q       <= tmo_d;
      enable_q    <= enable_d;
    end
  end

  assign msg.Msg_ready = ready_q;
  assign Voice_note    = note_q;
  assign Voice_vel     = vel_q;
  assign Voice_gate    = gate_q;
  assign Steal         = steal_q;
  assign Enable        = enable_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Self-checking bench for midi_voice_allocator with 4 voices and a
// 20-cycle enable timeout.
module tb_midi_voice_allocator;
  import midi_voice_allocator_pkg::*;

  localparam int unsigned NV = 4;

  logic          clk = 1'b0;
  logic          rst_p;
  logic          mode;
  logic [15:0]   chan_mask;
  logic [27:0]   voice_note;
  logic [27:0]   voice_vel;
  logic [NV-1:0] voice_gate;
  logic          steal;
  logic          enable;

  int n_tests = 0;
  int n_fail  = 0;

  midi_voice_allocator_if bus ();

  midi_voice_allocator #(
    .NUM_VOICES  (NV),
    .AGE_W       (8),
    .TIMEOUT_CYC (20),
    .TMO_W       (32)
  ) dut (
    .Clk        (clk),
    .Rst_p      (rst_p),
    .msg        (bus.slave),
    .Mode       (mode),
    .Chan_mask  (chan_mask),
    .Voice_note (voice_note),
    .Voice_vel  (voice_vel),
    .Voice_gate (voice_gate),
    .Steal      (steal),
    .Enable     (enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [15:0] mask;
    logic [23:0] msg;
    logic [3:0]  gate;
    logic [27:0] note;
    logic [27:0] vel;
    logic        steal;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic md, input logic [15:0] msk, input logic [23:0] m,
                              input logic [3:0] g, input logic [27:0] n, input logic [27:0] v,
                              input logic s);
    vec_t r;
    r.mode = md; r.mask = msk; r.msg = m; r.gate = g; r.note = n; r.vel = v; r.steal = s;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the commit edge.
  task automatic send(input logic [23:0] m, input logic md, input logic [15:0] msk,
                      input bit chk_ready);
    int waited;
    waited = 0;
    while (!bus.Msg_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.Msg_ready) check("ready_wait", 32'(bus.Msg_ready), 32'd1);
    bus.Msg_valid = 1'b1;
    bus.Msg_data  = m;
    mode          = md;
    chan_mask     = msk;
    @(posedge clk);
    @(negedge clk);
    bus.Msg_valid = 1'b0;
    if (chk_ready) check("ready_lookup", 32'(bus.Msg_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (chk_ready) check("ready_commit", 32'(bus.Msg_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (chk_ready) check("ready_idle", 32'(bus.Msg_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_gate"},  32'(voice_gate), 32'd0);
    check({tag, "_note"},  32'(voice_note), 32'd0);
    check({tag, "_vel"},   32'(voice_vel),  32'd0);
    check({tag, "_steal"}, 32'(steal),      32'd0);
    check({tag, "_en"},    32'(enable),     32'd1);
    check({tag, "_ready"}, 32'(bus.Msg_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int zeros;
    int first;

    // Notes/vels listed voice3..voice0.
    vecs[0]  = mk(1'b0, 16'h0000, 24'h903C64, 4'b0001, {7'h00,7'h00,7'h00,7'h3C}, {7'h00,7'h00,7'h00,7'h64}, 1'b0);
    vecs[1]  = mk(1'b0, 16'h0000, 24'h803C00, 4'b0000, {7'h00,7'h00,7'h00,7'h3C}, {7'h00,7'h00,7'h00,7'h00}, 1'b0);
    vecs[2]  = mk(1'b0, 16'h0000, 24'h914050, 4'b0010, {7'h00,7'h00,7'h40,7'h3C}, {7'h00,7'h00,7'h50,7'h00}, 1'b0);
    vecs[3]  = mk(1'b0, 16'h0000, 24'h814100, 4'b0010, {7'h00,7'h00,7'h40,7'h3C}, {7'h00,7'h00,7'h50,7'h00}, 1'b0);
    vecs[4]  = mk(1'b0, 16'h0000, 24'h953010, 4'b0010, {7'h00,7'h00,7'h40,7'h3C}, {7'h00,7'h00,7'h50,7'h00}, 1'b0);
    vecs[5]  = mk(1'b0, 16'h0000, 24'h914000, 4'b0000, {7'h00,7'h00,7'h40,7'h3C}, {7'h00,7'h00,7'h00,7'h00}, 1'b0);
    vecs[6]  = mk(1'b0, 16'h0000, 24'hA03C10, 4'b0000, {7'h00,7'h00,7'h40,7'h3C}, {7'h00,7'h00,7'h00,7'h00}, 1'b0);
    vecs[7]  = mk(1'b1, 16'h0003, 24'h903C10, 4'b0001, {7'h00,7'h00,7'h40,7'h3C}, {7'h00,7'h00,7'h00,7'h10}, 1'b0);
    vecs[8]  = mk(1'b1, 16'h0003, 24'h903E11, 4'b0011, {7'h00,7'h00,7'h3E,7'h3C}, {7'h00,7'h00,7'h11,7'h10}, 1'b0);
    vecs[9]  = mk(1'b1, 16'h0003, 24'h904012, 4'b0111, {7'h00,7'h40,7'h3E,7'h3C}, {7'h00,7'h12,7'h11,7'h10}, 1'b0);
    vecs[10] = mk(1'b1, 16'h0003, 24'h904113, 4'b1111, {7'h41,7'h40,7'h3E,7'h3C}, {7'h13,7'h12,7'h11,7'h10}, 1'b0);
    vecs[11] = mk(1'b1, 16'h0003, 24'h904314, 4'b1111, {7'h41,7'h40,7'h3E,7'h43}, {7'h13,7'h12,7'h11,7'h14}, 1'b1);
    vecs[12] = mk(1'b1, 16'h0003, 24'h90407F, 4'b1111, {7'h41,7'h40,7'h3E,7'h43}, {7'h13,7'h7F,7'h11,7'h14}, 1'b0);
    vecs[13] = mk(1'b1, 16'h0003, 24'h904520, 4'b1111, {7'h41,7'h40,7'h45,7'h43}, {7'h13,7'h7F,7'h20,7'h14}, 1'b1);
    vecs[14] = mk(1'b1, 16'h0003, 24'h923030, 4'b1111, {7'h41,7'h40,7'h45,7'h43}, {7'h13,7'h7F,7'h20,7'h14}, 1'b0);
    vecs[15] = mk(1'b1, 16'h0003, 24'h913C22, 4'b1111, {7'h3C,7'h40,7'h45,7'h43}, {7'h22,7'h7F,7'h20,7'h14}, 1'b1);
    vecs[16] = mk(1'b1, 16'h0003, 24'h803C00, 4'b1111, {7'h3C,7'h40,7'h45,7'h43}, {7'h22,7'h7F,7'h20,7'h14}, 1'b0);
    vecs[17] = mk(1'b1, 16'h0003, 24'hB07B00, 4'b1000, {7'h3C,7'h40,7'h45,7'h43}, {7'h22,7'h00,7'h00,7'h00}, 1'b0);
    vecs[18] = mk(1'b1, 16'h0003, 24'h813C40, 4'b0000, {7'h3C,7'h40,7'h45,7'h43}, {7'h00,7'h00,7'h00,7'h00}, 1'b0);
    vecs[19] = mk(1'b1, 16'h0003, 24'hB00764, 4'b0000, {7'h3C,7'h40,7'h45,7'h43}, {7'h00,7'h00,7'h00,7'h00}, 1'b0);
    vecs[20] = mk(1'b0, 16'h0003, 24'h925033, 4'b0100, {7'h3C,7'h50,7'h45,7'h43}, {7'h00,7'h33,7'h00,7'h00}, 1'b0);
    vecs[21] = mk(1'b1, 16'h0003, 24'h905501, 4'b0101, {7'h3C,7'h50,7'h45,7'h55}, {7'h00,7'h33,7'h00,7'h01}, 1'b0);

    rst_p         = 1'b1;
    mode          = 1'b0;
    chan_mask     = 16'h0000;
    bus.Msg_valid = 1'b0;
    bus.Msg_data  = '0;
    repeat (2) @(negedge clk);
    rst_p = 1'b0;
    check_reset_state("reset");

    for (int i = 0; i < 22; i++) begin
      send(vecs[i].msg, vecs[i].mode, vecs[i].mask, i == 0);
      check($sformatf("v%0d_gate", i),  32'(voice_gate), 32'(vecs[i].gate));
      check($sformatf("v%0d_note", i),  32'(voice_note), 32'(vecs[i].note));
      check($sformatf("v%0d_vel", i),   32'(voice_vel),  32'(vecs[i].vel));
      check($sformatf("v%0d_steal", i), 32'(steal),      32'(vecs[i].steal));
    end

    // Reset with voices active.
    rst_p = 1'b1;
    @(negedge clk);
    rst_p = 1'b0;
    check_reset_state("reset2");

    // Timeout: one dropped message, no gates -> Enable low for exactly 20 cycles.
    bus.Msg_valid = 1'b1;
    bus.Msg_data  = 24'hB00764;
    @(posedge clk);
    @(negedge clk);
    bus.Msg_valid = 1'b0;
    check("tmo_en_accept", 32'(enable), 32'd1);
    zeros = 0;
    first = -1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!enable) begin
        zeros++;
        if (first < 0) first = k;
      end
    end
    check("tmo_low_cycles", 32'(zeros), 32'd20);
    check("tmo_first_low", 32'(first), 32'd1);
    check("tmo_en_final", 32'(enable), 32'd1);

    // A sounding voice holds the drivers on indefinitely.
    send(24'h903C10, 1'b0, 16'h0000, 1'b0);
    repeat (40) @(negedge clk);
    check("hold_gate", 32'(voice_gate), 32'd1);
    check("hold_en", 32'(enable), 32'd0);
    send(24'h803C00, 1'b0, 16'h0000, 1'b0);
    check("release_en_soon", 32'(enable), 32'd0);
    repeat (25) @(negedge clk);
    check("release_en_late", 32'(enable), 32'd1);

    // Reset during LOOKUP discards the message in flight.
    send(24'h903C10, 1'b0, 16'h0000, 1'b0);
    check("pre_rst_gate", 32'(voice_gate), 32'd1);
    bus.Msg_valid = 1'b1;
    bus.Msg_data  = 24'h914050;
    @(posedge clk);
    @(negedge clk);
    bus.Msg_valid = 1'b0;
    rst_p         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_p = 1'b0;
    check_reset_state("rst_lookup");
    repeat (4) @(negedge clk);
    check("rst_lookup_gate_after", 32'(voice_gate), 32'd0);
    check("rst_lookup_vel_after", 32'(voice_vel), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
